// File: rtl/line_mem_responder_pkg.sv
// Shared types for the line memory responder: controller states, request kind,
// and the words-per-line derivation used by the top and the bench alike.
package line_mem_responder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    GNT
  } state_t;

  typedef enum logic {
    RD,
    WR
  } op_t;

  function automatic int line_size(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

endpackage

// File: rtl/line_mem_responder_word_ram.sv
// Single-port synchronous word RAM: write-enable per word, registered read
// with one cycle of latency.
module word_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset branch on purpose; clearing a memory on reset
  // would turn it into a huge register file instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/line_mem_responder.sv
// Whole-line main-memory responder: fixed access latency, one word per cycle
// through a word RAM, one-cycle grant. Define MEM_STATS_EN to build counters.
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 8,
  parameter int LATENCY       = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         mem_rd_req,
  input  logic                                         mem_wr_req,
  input  logic [MEM_ADDR_LEN-1:0]                      mem_addr,
  input  logic [WORD_W*line_size(LINE_ADDR_LEN)-1:0]   mem_wr_line,
  output logic [WORD_W*line_size(LINE_ADDR_LEN)-1:0]   mem_rd_line,
  output logic                                         mem_gnt,
  output logic [31:0]                                  rd_cnt,
  output logic [31:0]                                  wr_cnt
);

  localparam int LINE_SIZE = line_size(LINE_ADDR_LEN);
  localparam int LINE_W    = WORD_W * LINE_SIZE;
  localparam int RAM_AW    = MEM_ADDR_LEN + LINE_ADDR_LEN;
  localparam int LAT_W     = 16;

  localparam logic [LAT_W-1:0]       LAT_INIT    = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);
  localparam logic [LINE_ADDR_LEN:0] IDX_LAST_WR = (LINE_ADDR_LEN + 1)'(LINE_SIZE - 1);
  localparam logic [LINE_ADDR_LEN:0] IDX_LAST_RD = (LINE_ADDR_LEN + 1)'(LINE_SIZE);

  state_t                    state, state_nxt;
  op_t                       op;
  logic [MEM_ADDR_LEN-1:0]   addr;
  logic [LINE_W-1:0]         wr_buf;
  logic [LINE_ADDR_LEN:0]    idx;
  logic [LINE_ADDR_LEN-1:0]  idx_lo, slot;
  logic [LAT_W-1:0]          lat_cnt;
  logic                      accept, xfer_done;
  logic                      ram_we;
  logic [WORD_W-1:0]         ram_wdata, ram_rdata;

  // Reads run one extra cycle so the last registered RAM word can be captured.
  assign xfer_done = (op == WR) ? (idx == IDX_LAST_WR) : (idx == IDX_LAST_RD);
  assign idx_lo    = idx[LINE_ADDR_LEN-1:0];
  assign slot      = LINE_ADDR_LEN'(idx - 1'b1);
  assign mem_gnt   = (state == GNT);

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise a path that skips an assignment infers a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: if (mem_wr_req || mem_rd_req) begin
        accept    = 1'b1;
        state_nxt = (LATENCY == 0) ? XFER : WAIT;
      end
      WAIT: if (lat_cnt == '0) state_nxt = XFER;
      XFER: if (xfer_done) state_nxt = GNT;
      GNT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op          <= RD;
      addr        <= '0;
      wr_buf      <= '0;
      idx         <= '0;
      lat_cnt     <= '0;
      mem_rd_line <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op      <= mem_wr_req ? WR : RD;
        addr    <= mem_addr;
        lat_cnt <= LAT_INIT;
        idx     <= '0;
        if (mem_wr_req) wr_buf <= mem_wr_line;
      end
      if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      if (state == XFER) begin
        idx <= idx + 1'b1;
        if (op == RD && idx != '0) mem_rd_line[WORD_W*int'(slot) +: WORD_W] <= ram_rdata;
      end
    end
  end

  assign ram_we    = (state == XFER) && (op == WR);
  assign ram_wdata = wr_buf[WORD_W*int'(idx_lo) +: WORD_W];

  word_ram #(
    .ADDR_W(RAM_AW),
    .DATA_W(WORD_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr ({addr, idx_lo}),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state == GNT) begin
      if (op == WR) wr_cnt <= wr_cnt + 1'b1;
      else          rd_cnt <= rd_cnt + 1'b1;
    end
  end
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: a default-latency instance and a
// LATENCY=0 instance, directed steps with a read-data scoreboard.
module tb_line_mem_responder;
  import line_mem_responder_pkg::*;

  localparam int LW = 256;
`ifdef MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rd, wr, rd_z, wr_z;
  logic [7:0]    addr, addr_z;
  logic [LW-1:0] wline, wline_z, rline, rline_z;
  logic          gnt, gnt_z;
  logic [31:0]   rcnt, wcnt, rcnt_z, wcnt_z;

  int cyc = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int exp_rd = 0, exp_wr = 0, exp_rd_z = 0, exp_wr_z = 0;
  logic [LW-1:0] model [int];
  logic [LW-1:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_mem_responder dut (
    .clk(clk), .rst(rst), .mem_rd_req(rd), .mem_wr_req(wr), .mem_addr(addr),
    .mem_wr_line(wline), .mem_rd_line(rline), .mem_gnt(gnt),
    .rd_cnt(rcnt), .wr_cnt(wcnt)
  );

  line_mem_responder #(.LATENCY(0)) dut_z (
    .clk(clk), .rst(rst), .mem_rd_req(rd_z), .mem_wr_req(wr_z), .mem_addr(addr_z),
    .mem_wr_line(wline_z), .mem_rd_line(rline_z), .mem_gnt(gnt_z),
    .rd_cnt(rcnt_z), .wr_cnt(wcnt_z)
  );

  function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writes update the model first so a simultaneous read expects the new line.
  task automatic drive(input bit sel, input bit rd_v, input bit wr_v,
                       input logic [7:0] a, input logic [LW-1:0] l);
    int key = (sel ? 256 : 0) + int'(a);
    if (wr_v) model[key] = l;
    if (rd_v) exp_q.push_back(model.exists(key) ? model[key] : '0);
    if (sel) begin rd_z = rd_v; wr_z = wr_v; addr_z = a; wline_z = l; end
    else     begin rd = rd_v;   wr = wr_v;   addr = a;   wline = l;   end
  endtask

  task automatic wait_gnt(input bit sel, input int c0, output int rel);
    bit found = 1'b0;
    rel = -1;
    for (int n = 0; n < 64 && !found; n++) begin
      if (sel ? gnt_z : gnt) begin
        rel   = cyc - c0;
        found = 1'b1;
      end else step();
    end
  endtask

  task automatic do_txn(input bit sel, input bit rd_v, input bit wr_v, input logic [7:0] a,
                        input logic [LW-1:0] l, input int exp_rel, input string tag);
    int c0, rel;
    c0 = cyc;
    drive(sel, rd_v, wr_v, a, l);
    wait_gnt(sel, c0, rel);
    check({tag, "_gnt_cycle"}, LW'(rel), LW'(exp_rel));
    if (rd_v && exp_q.size() > 0) check({tag, "_data"}, sel ? rline_z : rline, exp_q.pop_front());
    drive(sel, 1'b0, 1'b0, a, l);
    step();
    check({tag, "_gnt_pulse"}, LW'(sel ? gnt_z : gnt), '0);
    if (sel) begin exp_rd_z += int'(rd_v); exp_wr_z += int'(wr_v); end
    else     begin exp_rd   += int'(rd_v); exp_wr   += int'(wr_v); end
  endtask

  initial begin
    int c0, rel;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, '0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, '0);
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    check("rst_gnt", LW'(gnt), '0);
    check("rst_rline", rline, '0);
    check("rst_rcnt", LW'(rcnt), '0);
    check("rst_wcnt", LW'(wcnt), '0);
    check("rst_gnt_z", LW'(gnt_z), '0);
    check("rst_rline_z", rline_z, '0);

    // Basic write then read of line 0x05.
    do_txn(1'b0, 1'b0, 1'b1, 8'h05, mk_line(32'hA000_0000), 13, "wr05");
    do_txn(1'b0, 1'b1, 1'b0, 8'h05, '0, 14, "rd05");

    // Both requests high: write first, held read accepted the cycle after GNT.
    c0 = cyc;
    drive(1'b0, 1'b1, 1'b1, 8'h10, mk_line(32'hB000_0000));
    wait_gnt(1'b0, c0, rel);
    check("both_wr_gnt_cycle", LW'(rel), LW'(13));
    wr = 1'b0;
    step();
    wait_gnt(1'b0, c0, rel);
    check("both_rd_gnt_cycle", LW'(rel), LW'(28));
    if (exp_q.size() > 0) check("both_rd_data", rline, exp_q.pop_front());
    rd = 1'b0;
    step();
    exp_rd++;
    exp_wr++;

    // Address/data changed during WAIT must be ignored.
    do_txn(1'b0, 1'b0, 1'b1, 8'h21, mk_line(32'hD000_0000), 13, "wr21");
    c0 = cyc;
    drive(1'b0, 1'b0, 1'b1, 8'h20, mk_line(32'hC000_0000));
    repeat (2) step();
    addr  = 8'h21;
    wline = mk_line(32'hEEEE_0000);
    wait_gnt(1'b0, c0, rel);
    check("late_chg_gnt_cycle", LW'(rel), LW'(13));
    wr = 1'b0;
    step();
    exp_wr++;
    do_txn(1'b0, 1'b1, 1'b0, 8'h20, '0, 14, "rd20");
    do_txn(1'b0, 1'b1, 1'b0, 8'h21, '0, 14, "rd21");

    // Reset during read XFER (cycle 7 of the transaction) aborts it.
    drive(1'b0, 1'b1, 1'b0, 8'h05, '0);
    repeat (7) step();
    rst = 1'b1;
    rd  = 1'b0;
    void'(exp_q.pop_back());
    step();
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    check("abort_gnt", LW'(gnt), '0);
    check("abort_rline", rline, '0);
    check("abort_rcnt", LW'(rcnt), '0);
    check("abort_wcnt", LW'(wcnt), '0);
    repeat (3) step();
    check("abort_idle_gnt", LW'(gnt), '0);
    do_txn(1'b0, 1'b1, 1'b0, 8'h10, '0, 14, "rd10_post_rst");
    do_txn(1'b0, 1'b1, 1'b0, 8'h05, '0, 14, "rd05_post_rst");
    check("cnt_rd", LW'(rcnt), LW'(STATS ? exp_rd : 0));
    check("cnt_wr", LW'(wcnt), LW'(STATS ? exp_wr : 0));

    // Zero-latency instance: WAIT skipped entirely.
    do_txn(1'b1, 1'b0, 1'b1, 8'h03, mk_line(32'hF000_0000), 9, "z_wr03");
    do_txn(1'b1, 1'b1, 1'b0, 8'h03, '0, 10, "z_rd03");
    check("z_cnt_rd", LW'(rcnt_z), LW'(STATS ? exp_rd_z : 0));
    check("z_cnt_wr", LW'(wcnt_z), LW'(STATS ? exp_wr_z : 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
